// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared fetch-stage definitions: state encoding, NOP word, default widths,
// Rs/Rt field positions and the saturating stall-counter helper.
package fetch_stage_ctrl_pkg;

  localparam int unsigned AW_DEFAULT     = 16;
  localparam int unsigned IW_DEFAULT     = 16;
  localparam int unsigned RS_LSB_DEFAULT = 8;
  localparam int unsigned RT_LSB_DEFAULT = 4;

  // All-zero word doubles as the bubble/NOP encoding seen by the decoder.
  localparam logic [IW_DEFAULT-1:0] NOP_INSTR = 16'h0000;

  localparam logic [7:0] STALL_CNT_MAX = 8'hFF;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,  // request outstanding, imem_addr = PC
    ST_HOLD  = 1'b1   // word captured during a stall, request dropped
  } fetch_state_e;

  // Saturating 8-bit increment used by the stall counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == STALL_CNT_MAX) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_stage_ctrl_ifid.sv
// IF/ID pipeline register: load captures a fetched word as valid, flush
// turns the slot into a bubble (flush wins if both are raised).
module ifid_pipe_reg
  import fetch_stage_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned IW = IW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          flush_i,
  input  logic [IW-1:0] instr_i,
  input  logic [AW-1:0] pc_i,
  output logic [IW-1:0] instr_o,
  output logic [AW-1:0] pc_o,
  output logic          valid_o
);

  logic [IW-1:0] instr_q;
  logic [AW-1:0] pc_q;
  logic          valid_q;

  // IF/ID slot update: flush clears only the valid bit, load captures a new word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q <= IW'(NOP_INSTR);
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: owns the PC, the fetch request FSM, the one-word hold buffer
// used when a fetch completes during a stall, and the stall counter.
module fetch_stage_ctrl
  import fetch_stage_ctrl_pkg::*;
#(
  parameter int unsigned   AW       = AW_DEFAULT,
  parameter int unsigned   IW       = IW_DEFAULT,
  parameter int unsigned   PC_INC   = 1,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int unsigned   RS_LSB   = RS_LSB_DEFAULT,
  parameter int unsigned   RT_LSB   = RT_LSB_DEFAULT
) (
  input  logic          clk,
  input  logic          rest,
  input  logic          FrezePC,
  input  logic          FrezeIFID,
  input  logic          Redirect,
  input  logic [AW-1:0] RedirectPC,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] IFID_Instr,
  output logic [AW-1:0] IFID_PC,
  output logic          IFID_Valid,
  output logic [3:0]    IFID_Rs,
  output logic [3:0]    IFID_Rt,
  output logic [7:0]    StallCount
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] hold_instr_q, hold_instr_d;
  logic [AW-1:0] hold_pc_q, hold_pc_d;
  logic [7:0]    stall_cnt_q;

  logic          stall_s;
  logic          ifid_load_s;
  logic          ifid_flush_s;
  logic [IW-1:0] ifid_instr_in_s;
  logic [AW-1:0] ifid_pc_in_s;
  logic [AW-1:0] pc_next_s;

  // Both hazard-unit freezes are treated as one stall condition.
  assign stall_s   = FrezePC | FrezeIFID;
  assign pc_next_s = pc_q + AW'(PC_INC);

  // State, PC, hold buffer and stall counter registers.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      stall_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      if (stall_s) begin
        stall_cnt_q <= sat_inc8(stall_cnt_q);
      end
    end
  end

  // Next-state and IF/ID control, in priority order: redirect, then FSM state.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    hold_instr_d    = hold_instr_q;
    hold_pc_d       = hold_pc_q;
    ifid_load_s     = 1'b0;
    ifid_flush_s    = 1'b0;
    ifid_instr_in_s = imem_data;
    ifid_pc_in_s    = pc_q;

    if (Redirect) begin
      // Flush wins over stall; any word arriving this cycle or held is dropped.
      pc_d         = RedirectPC;
      ifid_flush_s = 1'b1;
      state_d      = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ack && !stall_s) begin
            ifid_load_s = 1'b1;
            pc_d        = pc_next_s;
          end else if (imem_ack && stall_s) begin
            // Park the word so the request can drop until the stall clears.
            hold_instr_d = imem_data;
            hold_pc_d    = pc_q;
            state_d      = ST_HOLD;
          end else if (!stall_s) begin
            ifid_flush_s = 1'b1;  // memory still busy: feed a bubble
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (!stall_s) begin
            ifid_load_s     = 1'b1;
            ifid_instr_in_s = hold_instr_q;
            ifid_pc_in_s    = hold_pc_q;
            pc_d            = pc_next_s;
            state_d         = ST_FETCH;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  ifid_pipe_reg #(
    .AW(AW),
    .IW(IW)
  ) u_ifid (
    .clk_i   (clk),
    .rst_ni  (rest),
    .load_i  (ifid_load_s),
    .flush_i (ifid_flush_s),
    .instr_i (ifid_instr_in_s),
    .pc_i    (ifid_pc_in_s),
    .instr_o (IFID_Instr),
    .pc_o    (IFID_PC),
    .valid_o (IFID_Valid)
  );

  // Request is gated by reset so memory never sees a fetch while held in reset.
  assign imem_req   = rest & (state_q == ST_FETCH);
  assign imem_addr  = pc_q;
  assign IFID_Rs    = IFID_Valid ? IFID_Instr[RS_LSB +: 4] : 4'h0;
  assign IFID_Rt    = IFID_Valid ? IFID_Instr[RT_LSB +: 4] : 4'h0;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Self-checking bench for fetch_stage_ctrl: directed scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_fetch_stage_ctrl;

  logic        clk;
  logic        rest;
  logic        FrezePC;
  logic        FrezeIFID;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] IFID_Instr;
  logic [15:0] IFID_PC;
  logic        IFID_Valid;
  logic [3:0]  IFID_Rs;
  logic [3:0]  IFID_Rt;
  logic [7:0]  StallCount;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed directly in terms of the fetch rules.
  logic [15:0] m_pc;
  logic        m_holding;
  logic [15:0] m_hold_instr;
  logic [15:0] m_hold_pc;
  logic [15:0] m_if_instr;
  logic [15:0] m_if_pc;
  logic        m_if_valid;
  int          m_stalls;

  fetch_stage_ctrl dut (
    .clk        (clk),
    .rest       (rest),
    .FrezePC    (FrezePC),
    .FrezeIFID  (FrezeIFID),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .IFID_Instr (IFID_Instr),
    .IFID_PC    (IFID_PC),
    .IFID_Valid (IFID_Valid),
    .IFID_Rs    (IFID_Rs),
    .IFID_Rt    (IFID_Rt),
    .StallCount (StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc         = 16'h0000;
    m_holding    = 1'b0;
    m_hold_instr = 16'h0000;
    m_hold_pc    = 16'h0000;
    m_if_instr   = 16'h0000;
    m_if_pc      = 16'h0000;
    m_if_valid   = 1'b0;
    m_stalls     = 0;
  endtask

  // One clock of the reference model, using the inputs applied this cycle.
  task automatic model_step();
    logic stall;
    stall = FrezePC | FrezeIFID;
    if (stall) m_stalls = m_stalls + 1;
    if (Redirect) begin
      m_pc       = RedirectPC;
      m_if_valid = 1'b0;
      m_holding  = 1'b0;
    end else if (!m_holding) begin
      if (imem_ack && !stall) begin
        m_if_instr = imem_data;
        m_if_pc    = m_pc;
        m_if_valid = 1'b1;
        m_pc       = m_pc + 16'd1;
      end else if (imem_ack) begin
        m_hold_instr = imem_data;
        m_hold_pc    = m_pc;
        m_holding    = 1'b1;
      end else if (!stall) begin
        m_if_valid = 1'b0;
      end
    end else if (!stall) begin
      m_if_instr = m_hold_instr;
      m_if_pc    = m_hold_pc;
      m_if_valid = 1'b1;
      m_pc       = m_pc + 16'd1;
      m_holding  = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("req",    {31'd0, imem_req},   {31'd0, !m_holding});
    chk("addr",   {16'd0, imem_addr},  {16'd0, m_pc});
    chk("valid",  {31'd0, IFID_Valid}, {31'd0, m_if_valid});
    chk("stallcnt", {24'd0, StallCount}, (m_stalls > 255) ? 32'd255 : 32'(m_stalls));
    if (m_if_valid) begin
      chk("instr", {16'd0, IFID_Instr}, {16'd0, m_if_instr});
      chk("ifpc",  {16'd0, IFID_PC},    {16'd0, m_if_pc});
      chk("rs",    {28'd0, IFID_Rs},    {28'd0, m_if_instr[11:8]});
      chk("rt",    {28'd0, IFID_Rt},    {28'd0, m_if_instr[7:4]});
    end else begin
      chk("rs_bubble", {28'd0, IFID_Rs}, 32'd0);
      chk("rt_bubble", {28'd0, IFID_Rt}, 32'd0);
    end
  endtask

  // Apply inputs, clock once, then compare every output against the model.
  task automatic do_cycle(input logic fp, input logic fi, input logic rd,
                          input logic [15:0] rpc, input logic ak, input logic [15:0] dat);
    FrezePC    = fp;
    FrezeIFID  = fi;
    Redirect   = rd;
    RedirectPC = rpc;
    imem_ack   = ak & !m_holding;  // memory only answers an active request
    imem_data  = dat;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    rest = 1'b0; FrezePC = 1'b0; FrezeIFID = 1'b0; Redirect = 1'b0;
    RedirectPC = 16'h0000; imem_ack = 1'b0; imem_data = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    chk("rst_valid", {31'd0, IFID_Valid}, 32'd0);
    chk("rst_addr",  {16'd0, imem_addr},  32'h0000);
    chk("rst_ifpc",  {16'd0, IFID_PC},    32'h0000);
    chk("rst_instr", {16'd0, IFID_Instr}, 32'h0000);
    chk("rst_cnt",   {24'd0, StallCount}, 32'd0);
    rest = 1'b1;
    #1;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);

    // Streaming with single-cycle ack.
    do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111);
    chk("stream0_pc",  {16'd0, IFID_PC},    32'h0000);
    chk("stream0_ins", {16'd0, IFID_Instr}, 32'h1111);
    do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222);
    chk("stream1_pc",  {16'd0, IFID_PC},    32'h0001);
    chk("stream_addr", {16'd0, imem_addr},  32'h0002);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0A00 + 16'(i));
    chk("at_pc5", {16'd0, imem_addr}, 32'h0005);

    // Fetch completes under stall: word parked, request dropped.
    do_cycle(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3456);
    chk("hold_req",   {31'd0, imem_req},   32'd0);
    chk("hold_instr", {16'd0, IFID_Instr}, 32'h0A02);
    do_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("hold2_addr", {16'd0, imem_addr},  32'h0005);
    do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("release_instr", {16'd0, IFID_Instr}, 32'h3456);
    chk("release_pc",    {16'd0, IFID_PC},    32'h0005);
    chk("release_addr",  {16'd0, imem_addr},  32'h0006);

    // Redirect while stalled in HOLD.
    do_cycle(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h7777);
    do_cycle(1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000);
    chk("redir_valid", {31'd0, IFID_Valid}, 32'd0);
    chk("redir_req",   {31'd0, imem_req},   32'd1);
    chk("redir_addr",  {16'd0, imem_addr},  32'h0040);

    // Slow memory: three cycles without ack, then data.
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      chk("slow_valid", {31'd0, IFID_Valid}, 32'd0);
      chk("slow_addr",  {16'd0, imem_addr},  32'h0040);
    end
    do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF);
    chk("slow_instr", {16'd0, IFID_Instr}, 32'hBEEF);
    chk("slow_pc",    {16'd0, IFID_PC},    32'h0040);

    // Stall counter saturation.
    for (int i = 0; i < 300; i++) do_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("cnt_sat", {24'd0, StallCount}, 32'd255);

    // Reset in the middle of an outstanding fetch takes effect immediately.
    rest = 1'b0;
    #1;
    model_reset();
    chk("midrst_req",   {31'd0, imem_req},   32'd0);
    chk("midrst_addr",  {16'd0, imem_addr},  32'h0000);
    chk("midrst_valid", {31'd0, IFID_Valid}, 32'd0);
    chk("midrst_cnt",   {24'd0, StallCount}, 32'd0);
    @(posedge clk);
    #1;
    rest = 1'b1;

    // PC wrap at the top of the address space.
    do_cycle(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000);
    do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
    chk("wrap_addr", {16'd0, imem_addr}, 32'h0000);
    chk("wrap_ifpc", {16'd0, IFID_PC},   32'hFFFF);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      do_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 15) == 0, 16'($urandom),
               $urandom_range(0, 2) != 0, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
